// File: rtl/data_ram_hs.sv
// Word-organised little-endian data RAM for the load/store unit: RISC-V sub-word
// access behind a single-outstanding valid/ready handshake with a post-reset clear.
module data_ram_hs #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int INIT_CLEAR  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int PTR_W = (DEPTH_WORDS > 2) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH_WORDS - 1);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic [1:0] ST_RST  = (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             acc, misal, oor, illegal, acc_err, wr_en;
  logic [PTR_W-1:0] widx;
  logic [3:0]       be;
  logic [31:0]      wrep, rword, wword;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_fmt = {{24{b[7]}}, b};
      3'b001:  load_fmt = {{16{h[15]}}, h};
      3'b010:  load_fmt = w;
      3'b100:  load_fmt = {24'h0, b};
      3'b101:  load_fmt = {16'h0, h};
      default: load_fmt = 32'h0;
    endcase
  endfunction

  assign req_ready  = (state_q == ST_IDLE) && done_q;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign resp_err   = (state_q == ST_RESP) && err_q;
  assign init_done  = done_q;
  assign acc        = req_valid && req_ready;

  // Request decode, error classification and store lane merge
  always_comb begin
    widx    = req_addr[PTR_W+1:2];
    rword   = mem[widx];
    misal   = ((req_funct3 == 3'b001 || req_funct3 == 3'b101) && req_addr[0]) ||
              (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
    oor     = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_we && req_funct3[2]);
    acc_err = misal || oor || illegal;
    wr_en   = acc && req_we && !acc_err;
    be      = 4'b0000;
    wrep    = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << req_addr[1:0];
        wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wword[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rword[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (INIT_CLEAR == 0) done_d = 1'b1;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (acc) begin
          err_d   = acc_err;
          rdata_d = (acc_err || req_we) ? 32'h0 : load_fmt(rword, req_funct3, req_addr[1:0]);
          cnt_d   = 2'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) state_d = ST_RESP;
      end
      default: begin
        if (resp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      ptr_q   <= '0;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Response payload and array contents carry no reset; outputs are gated by state
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    err_q   <= err_d;
    if (state_q == ST_INIT) mem[ptr_q] <= 32'h0;
    else if (wr_en)         mem[widx]  <= wword;
  end

endmodule

// File: tb/tb_data_ram_hs.sv
// Directed bench for data_ram_hs: a LATENCY=1 and a LATENCY=3 instance (16 words each)
// with expected responses queued at request time and compared when they emerge.
module tb_data_ram_hs;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_n, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, init_done;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] resp_rdata [2];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  data_ram_hs #(.DEPTH_WORDS(16), .LATENCY(1), .INIT_CLEAR(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .init_done(init_done[0]));

  data_ram_hs #(.DEPTH_WORDS(16), .LATENCY(3), .INIT_CLEAR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .init_done(init_done[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_init(input int d, input string tag);
    int n = 0;
    while (init_done[d] !== 1'b1 && n < 100) begin
      chk({tag, "_ready_low"}, {31'h0, req_ready[d]}, 32'h0);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_cycles"}, n, 16);
  endtask

  task automatic do_req(input int d, input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat);
    int   n = 0;
    exp_t e;
    sb.push_back('{rdata: er, err: ee});
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_addr[d] = 32'hFFFF_FFFF; req_wdata[d] = 32'h5A5A_5A5A;
    n = 0;
    while (resp_valid[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat - 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_rdata"}, resp_rdata[d], e.rdata);
    chk({tag, "_err"}, {31'h0, resp_err[d]}, {31'h0, e.err});
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {31'h0, resp_valid[d]}, 32'h0);
    chk({tag, "_idle_ready"}, {31'h0, req_ready[d]}, 32'h1);
  endtask

  initial begin
    exp_t e;
    rst_n = 2'b00; req_valid = 2'b00; req_we = 2'b00; resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_funct3[i] = 3'b010; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_valid", {30'h0, resp_valid}, 32'h0);
    chk("rst_err", {30'h0, resp_err}, 32'h0);
    chk("rst_rdata", resp_rdata[0], 32'h0);
    chk("rst_done", {30'h0, init_done}, 32'h0);
    rst_n = 2'b11;
    wait_init(0, "init0");
    chk("init1_done", {31'h0, init_done[1]}, 32'h1);

    do_req(0, "lw_last", 1'b0, 3'b010, 32'h3C, 32'h0, 32'h0, 1'b0, 1);
    do_req(0, "sw_last", 1'b1, 3'b010, 32'h3C, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    do_req(0, "lw_last2", 1'b0, 3'b010, 32'h3C, 32'h0, 32'hDEADBEEF, 1'b0, 1);

    do_req(0, "sw0", 1'b1, 3'b010, 32'h0, 32'h01234567, 32'h0, 1'b0, 1);
    do_req(0, "sh2", 1'b1, 3'b001, 32'h2, 32'h9999AABB, 32'h0, 1'b0, 1);
    do_req(0, "sb1", 1'b1, 3'b000, 32'h1, 32'h12345677, 32'h0, 1'b0, 1);
    do_req(0, "lw_mix", 1'b0, 3'b010, 32'h0, 32'h0, 32'hAABB7767, 1'b0, 1);

    do_req(0, "sw_a", 1'b1, 3'b010, 32'h0, 32'h00112233, 32'h0, 1'b0, 1);
    do_req(0, "sw_b", 1'b1, 3'b010, 32'h4, 32'hAABBCCDD, 32'h0, 1'b0, 1);
    do_req(0, "lb7", 1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFFAA, 1'b0, 1);
    do_req(0, "lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h000000AA, 1'b0, 1);
    do_req(0, "lh6", 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFFAABB, 1'b0, 1);
    do_req(0, "lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 32'h0000AABB, 1'b0, 1);
    do_req(0, "lh2", 1'b0, 3'b001, 32'h2, 32'h0, 32'h00000011, 1'b0, 1);
    do_req(0, "lb1", 1'b0, 3'b000, 32'h1, 32'h0, 32'h00000022, 1'b0, 1);
    do_req(0, "lbu4", 1'b0, 3'b100, 32'h4, 32'h0, 32'h000000DD, 1'b0, 1);

    do_req(0, "err_lw2", 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 1);
    do_req(0, "err_sh3", 1'b1, 3'b001, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    do_req(0, "err_lb_oor", 1'b0, 3'b000, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    do_req(0, "err_sw_oor", 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    do_req(0, "err_f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    do_req(0, "err_sbu", 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    do_req(0, "lw_after_err", 1'b0, 3'b010, 32'h0, 32'h0, 32'h00112233, 1'b0, 1);

    do_req(1, "l3_sw8", 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 3);
    do_req(1, "l3_lhu", 1'b0, 3'b101, 32'hA, 32'h0, 32'h0000CAFE, 1'b0, 3);

    // Backpressure on the LATENCY=3 instance
    resp_ready[1] = 1'b0;
    sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h8;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_addr[1] = 32'h3C; req_funct3[1] = 3'b000;
    chk("bp_n0", {31'h0, resp_valid[1]}, 32'h0);
    @(posedge clk); #1;
    chk("bp_n1", {31'h0, resp_valid[1]}, 32'h0);
    @(posedge clk); #1;
    chk("bp_n2", {31'h0, resp_valid[1]}, 32'h1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {31'h0, resp_valid[1]}, 32'h1);
      chk("bp_hold_rdata", resp_rdata[1], e.rdata);
      chk("bp_hold_err", {31'h0, resp_err[1]}, {31'h0, e.err});
      chk("bp_hold_ready", {31'h0, req_ready[1]}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'h0, resp_valid[1]}, 32'h0);
    chk("bp_release_ready", {31'h0, req_ready[1]}, 32'h1);

    // Reset while the LATENCY=3 instance is waiting
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h8;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_valid", {31'h0, resp_valid[1]}, 32'h0);
    rst_n[1] = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, resp_valid[1]}, 32'h0);
    chk("mid_rst_ready", {31'h0, req_ready[1]}, 32'h0);
    chk("mid_rst_done", {31'h0, init_done[1]}, 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_hold_valid", {31'h0, resp_valid[1]}, 32'h0);
    rst_n[1] = 1'b1;
    wait_init(1, "reinit1");
    do_req(1, "l3_cleared", 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 3);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
